// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: FSM states,
// the per-stage pipe-control bundle and default counter width.
package pipeline_stall_ctrl_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int LB_CNT_W  = 2;   // holds LB_EXTRA (0..3)
   localparam int STATE_W   = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN      = 2'd0,
      ST_LB_HOLD  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_e;

   // One bit per pipe-register control, in port order.
   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
      logic back_write;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   localparam pipe_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Count up on i_inc, stick at all-ones, synchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_cnt <= '0;
      else if (i_clr)               r_cnt <= '0;
      else if (i_inc && ~&r_cnt)    r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: maps hazard / branch / memory-wait events
// onto PC, IF/ID, ID/EX and back-end pipe register controls, and owns
// the extra bubbles a load->branch dependency needs.
module pipeline_stall_ctrl
   import pipeline_stall_ctrl_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int LB_EXTRA = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_stall_req,
   input  logic               i_idex_memread,
   input  logic               i_ifid_branch,
   input  logic               i_branch_taken,
   input  logic               i_mem_busy,
   output logic               o_pc_write,
   output logic               o_ifid_write,
   output logic               o_ifid_flush,
   output logic               o_idex_bubble,
   output logic               o_back_write,
   output logic [CNT_W-1:0]   o_stall_cycles,
   output logic [CNT_W-1:0]   o_flush_count,
   output logic [STATE_W-1:0] o_busy_state
);

   localparam logic [LB_CNT_W-1:0] LB_LOAD = LB_CNT_W'(LB_EXTRA);

   state_e              r_state, r_sav_state;
   state_e              w_nxt_state, w_nxt_sav, w_eff_state;
   logic [LB_CNT_W-1:0] r_bub_cnt, w_nxt_bub_cnt;
   pipe_ctrl_t          w_ctrl;
   logic                w_lb_start;

   // While waiting on memory the saved state is what the pipe resumes
   // into, so the release cycle already acts as that state (no lost cycle).
   assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_sav_state : r_state;
   assign w_lb_start  = i_stall_req && i_idex_memread && i_ifid_branch && (LB_EXTRA > 0);

   // State, bubble down-counter and MEM_WAIT save register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_sav_state <= ST_RUN;
         r_bub_cnt   <= '0;
      end else begin
         r_state     <= w_nxt_state;
         r_sav_state <= w_nxt_sav;
         r_bub_cnt   <= w_nxt_bub_cnt;
      end
   end

   // Next state: memory freeze first; the bubble counter simply holds
   // during the freeze, so the owed bubbles survive it unchanged.
   always_comb begin
      w_nxt_state   = ST_RUN;
      w_nxt_sav     = r_sav_state;
      w_nxt_bub_cnt = r_bub_cnt;
      if (i_mem_busy) begin
         w_nxt_state = ST_MEM_WAIT;
         if (r_state == ST_RUN || r_state == ST_LB_HOLD) w_nxt_sav = r_state;
         else if (r_state != ST_MEM_WAIT)                w_nxt_sav = ST_RUN;
      end else begin
         case (w_eff_state)
            ST_RUN: begin
               if (w_lb_start) begin
                  w_nxt_state   = ST_LB_HOLD;
                  w_nxt_bub_cnt = LB_LOAD;
               end
            end
            ST_LB_HOLD: begin
               w_nxt_bub_cnt = r_bub_cnt - 1'b1;
               w_nxt_state   = (r_bub_cnt <= 1) ? ST_RUN : ST_LB_HOLD;
            end
            default: w_nxt_state = ST_RUN;
         endcase
      end
   end

   // Pipe controls: reset > freeze > owed bubble > stall > taken branch > run.
   always_comb begin
      w_ctrl = CTRL_NORMAL;
      if (!rst_n)             w_ctrl = CTRL_RESET;
      else if (i_mem_busy)    w_ctrl = CTRL_FREEZE;
      else begin
         case (w_eff_state)
            ST_RUN: begin
               if (i_stall_req)         w_ctrl = CTRL_STALL;
               else if (i_branch_taken) w_ctrl = CTRL_BRANCH;
               else                     w_ctrl = CTRL_NORMAL;
            end
            ST_LB_HOLD: w_ctrl = CTRL_STALL;
            default:    w_ctrl = CTRL_STALL;  // corrupt state: hold pipe safely
         endcase
      end
   end

   assign o_pc_write    = w_ctrl.pc_write;
   assign o_ifid_write  = w_ctrl.ifid_write;
   assign o_ifid_flush  = w_ctrl.ifid_flush;
   assign o_idex_bubble = w_ctrl.idex_bubble;
   assign o_back_write  = w_ctrl.back_write;
   assign o_busy_state  = r_state;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_ctrl.idex_bubble),
      .i_clr (1'b0),
      .o_cnt (o_stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_ctrl.ifid_flush),
      .i_clr (1'b0),
      .o_cnt (o_flush_count)
   );

endmodule
